// File: rtl/tsu_queue_mux.sv
// Round-robin collector that drains CH_NUM tsu_queue read ports into a single
// channel-tagged first-word-fall-through stream for the host.
module tsu_queue_mux #(
  parameter  int CH_NUM = 2,
  parameter  int DATA_W = 92,
  parameter  int STAT_W = 8,
  parameter  int DEPTH  = 16,
  localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_NUM-1:0]        ch_mask,
  input  logic [CH_NUM*STAT_W-1:0] q_rd_stat,
  input  logic [CH_NUM*DATA_W-1:0] q_rd_data,
  output logic [CH_NUM-1:0]        q_rd_en,
  output logic [CH_NUM-1:0]        ch_pend,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W+DATA_W-1:0]   out_data,
  output logic [LW-1:0]            out_level,
  output logic [15:0]              drop_cnt
);

  typedef enum logic [1:0] {IDLE, RD, CAP} state_t;

  localparam int              CH_P     = 1 << CH_W;
  localparam int              SW1      = CH_W + 1;
  localparam logic [SW1-1:0]  CH_NUM_S = SW1'(CH_NUM);
  localparam logic [LW-1:0]   DEPTH_L  = LW'(DEPTH);

  state_t                 state, state_next;
  logic [CH_W-1:0]        grant, last, pick;
  logic                   found;
  logic [SW1-1:0]         cand;
  logic [CH_NUM-1:0]      pend_next;
  logic [CH_P-1:0]        pend_pad;
  logic [DATA_W-1:0]      data_arr [CH_P];
  logic                   push, push_ok, pop, full;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CH_W+DATA_W-1:0] mem [DEPTH];

  // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    pend_next = '0;
    for (int k = 0; k < CH_NUM; k++)
      pend_next[k] = ch_mask[k] && (q_rd_stat[k*STAT_W +: STAT_W] != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ch_pend <= '0;
    else        ch_pend <= pend_next;
  end

  // Pad the channel space to a power of two so a CH_W-bit index never runs off the end.
  always_comb begin
    pend_pad = '0;
    pend_pad[CH_NUM-1:0] = ch_pend;
    for (int k = 0; k < CH_P; k++)   data_arr[k] = '0;
    for (int k = 0; k < CH_NUM; k++) data_arr[k] = q_rd_data[k*DATA_W +: DATA_W];
  end

  // Rotating search starting just after the last served channel.
  always_comb begin
    found = 1'b0;
    pick  = last;
    cand  = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      cand = SW1'(last) + SW1'(i);
      if (cand >= CH_NUM_S) cand = cand - CH_NUM_S;
      if (!found && pend_pad[cand[CH_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[CH_W-1:0];
      end
    end
  end

  assign full = (out_level == DEPTH_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found && !full) state_next = RD;
      RD:      state_next = CAP;
      CAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    q_rd_en = '0;
    push    = 1'b0;
    case (state)
      RD:      q_rd_en = CH_NUM'(1) << grant;
      CAP:     push    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
      last  <= CH_W'(CH_NUM - 1);
    end else begin
      if (state == IDLE && found && !full) grant <= pick;
      if (state == CAP)                    last  <= grant;
    end
  end

  assign push_ok   = push && !full;
  assign out_valid = (out_level != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; out_valid qualifies every read of it.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {grant, data_arr[grant]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_level <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   out_level <= out_level + 1'b1;
        2'b01:   out_level <= out_level - 1'b1;
        default: ;
      endcase
      if (push && full && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_tsu_queue_mux.sv
// Self-checking bench for tsu_queue_mux: behavioural source queues plus a
// transaction-level round-robin model that predicts the tagged output stream.
module tb_tsu_queue_mux;

  localparam int CH  = 4;
  localparam int DW  = 92;
  localparam int SW  = 8;
  localparam int DEP = 4;
  localparam int CW  = 2;
  localparam int LW  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH-1:0]     ch_mask;
  logic [CH*SW-1:0]  q_rd_stat;
  logic [CH*DW-1:0]  q_rd_data;
  logic [CH-1:0]     q_rd_en;
  logic [CH-1:0]     ch_pend;
  logic              out_valid;
  logic              out_ready;
  logic [CW+DW-1:0]  out_data;
  logic [LW-1:0]     out_level;
  logic [15:0]       drop_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int model_last   = CH - 1;

  logic [DW-1:0]    src_q [CH][$];
  logic [DW-1:0]    mdl_q [CH][$];
  logic [CW+DW-1:0] exp_q [$];
  int               rd_cyc [$];

  tsu_queue_mux #(.CH_NUM(CH), .DATA_W(DW), .STAT_W(SW), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .ch_mask(ch_mask), .q_rd_stat(q_rd_stat),
    .q_rd_data(q_rd_data), .q_rd_en(q_rd_en), .ch_pend(ch_pend),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_level(out_level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic refresh_stat();
    for (int k = 0; k < CH; k++) q_rd_stat[k*SW +: SW] = SW'(src_q[k].size());
  endtask

  // Source queues: a strobed read presents the head entry for the following cycle.
  always @(negedge clk) begin
    if (q_rd_en != '0) begin
      rd_cyc.push_back(cyc);
      for (int k = 0; k < CH; k++)
        if (q_rd_en[k] && src_q[k].size() > 0) q_rd_data[k*DW +: DW] = src_q[k].pop_front();
      refresh_stat();
    end
  end

  task automatic load(input int k, input int n);
    logic [95:0] r;
    for (int i = 0; i < n; i++) begin
      r = {$urandom(), $urandom(), $urandom()};
      src_q[k].push_back(r[DW-1:0]);
      mdl_q[k].push_back(r[DW-1:0]);
    end
    refresh_stat();
  endtask

  // Round-robin over enabled non-empty channels, starting after the last one served.
  task automatic build_expected(input logic [CH-1:0] mask);
    bit any;
    do begin
      any = 1'b0;
      for (int i = 1; i <= CH; i++) begin
        int k;
        k = (model_last + i) % CH;
        if (!any && mask[k] && mdl_q[k].size() > 0) begin
          any = 1'b1;
          exp_q.push_back({CW'(k), mdl_q[k].pop_front()});
          model_last = k;
        end
      end
    end while (any);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    tests_run++; if (q_rd_en !== '0)   begin tests_failed++; $display("FAIL reset_rd_en: got %b expected 0", q_rd_en); end
    tests_run++; if (ch_pend !== '0)   begin tests_failed++; $display("FAIL reset_ch_pend: got %b expected 0", ch_pend); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    tests_run++; if (out_level !== '0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", out_level); end
    tests_run++; if (drop_cnt !== '0)  begin tests_failed++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    rst_n = 1'b1;
    repeat (2) step();
    tests_run++; if (q_rd_en !== '0 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL idle_after_reset: rd_en %b valid %b expected 0/0", q_rd_en, out_valid);
    end
  endtask

  task automatic test_single();
    logic [CW+DW-1:0] want;
    want = {2'd1, 92'h123};
    out_ready = 1'b0;
    rd_cyc.delete();
    src_q[1].push_back(92'h123);
    refresh_stat();
    for (int s = 1; s <= 4; s++) begin
      step();
      tests_run++; if (q_rd_en !== ((s == 2) ? 4'b0010 : 4'b0000)) begin
        tests_failed++; $display("FAIL single_rd_en_c%0d: got %b expected %b", s, q_rd_en, (s == 2) ? 4'b0010 : 4'b0000);
      end
      tests_run++; if (out_valid !== (s == 4)) begin
        tests_failed++; $display("FAIL single_valid_c%0d: got %b expected %b", s, out_valid, s == 4);
      end
    end
    model_last = 1;
    tests_run++; if (out_data !== want) begin tests_failed++; $display("FAIL single_data: got %h expected %h", out_data, want); end
    tests_run++; if (out_level !== 3'd1) begin tests_failed++; $display("FAIL single_level: got %0d expected 1", out_level); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests_run++; if (out_level !== 3'd0 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL single_pop: level %0d valid %b expected 0/0", out_level, out_valid);
    end
    repeat (4) step();
    tests_run++; if (rd_cyc.size() != 1) begin tests_failed++; $display("FAIL single_reads: got %0d expected 1", rd_cyc.size()); end
  endtask

  task automatic test_round_robin();
    out_ready = 1'b1;
    rd_cyc.delete();
    for (int k = 0; k < CH; k++) load(k, 2);
    build_expected('1);
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
      if (out_valid) begin
        tests_run++; if (out_data !== exp_q[0]) begin
          tests_failed++; $display("FAIL rr_data: got %h expected %h", out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      step();
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rr_timeout: %0d entries missing, expected 0", exp_q.size()); end
    repeat (4) step();
    tests_run++; if (rd_cyc.size() != 8) begin tests_failed++; $display("FAIL rr_reads: got %0d expected 8", rd_cyc.size()); end
    for (int i = 1; i < rd_cyc.size(); i++) begin
      tests_run++; if (rd_cyc[i] - rd_cyc[i-1] != 3) begin
        tests_failed++; $display("FAIL rr_spacing_%0d: got %0d cycles expected 3", i, rd_cyc[i] - rd_cyc[i-1]);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    rd_cyc.delete();
    load(0, 10);
    build_expected('1);
    repeat (40) step();
    tests_run++; if (rd_cyc.size() != DEP) begin tests_failed++; $display("FAIL bp_reads: got %0d expected %0d", rd_cyc.size(), DEP); end
    tests_run++; if (out_level !== 3'(DEP)) begin tests_failed++; $display("FAIL bp_level: got %0d expected %0d", out_level, DEP); end
    tests_run++; if (drop_cnt !== '0) begin tests_failed++; $display("FAIL bp_drop: got %0d expected 0", drop_cnt); end
    tests_run++; if (q_rd_en !== '0) begin tests_failed++; $display("FAIL bp_idle: got %b expected 0", q_rd_en); end
    out_ready = 1'b1;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      if (out_valid) begin
        tests_run++; if (out_data !== exp_q[0]) begin
          tests_failed++; $display("FAIL bp_data: got %h expected %h", out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      step();
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL bp_timeout: %0d entries missing, expected 0", exp_q.size()); end
    tests_run++; if (rd_cyc.size() != 10) begin tests_failed++; $display("FAIL bp_total: got %0d expected 10", rd_cyc.size()); end
    out_ready = 1'b0;
  endtask

  task automatic test_mask();
    out_ready = 1'b1;
    ch_mask = 4'b0001;
    rd_cyc.delete();
    load(0, 3);
    load(1, 2);
    build_expected(4'b0001);
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
      if (out_valid) begin
        tests_run++; if (out_data !== exp_q[0]) begin
          tests_failed++; $display("FAIL mask_data: got %h expected %h", out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      step();
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL mask_timeout: %0d entries missing, expected 0", exp_q.size()); end
    repeat (10) step();
    tests_run++; if (rd_cyc.size() != 3) begin tests_failed++; $display("FAIL mask_reads: got %0d expected 3", rd_cyc.size()); end
    tests_run++; if (ch_pend !== 4'b0000) begin tests_failed++; $display("FAIL mask_pend: got %b expected 0000", ch_pend); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mask_extra: got valid %b expected 0", out_valid); end
    ch_mask = '1;
    build_expected('1);
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
      if (out_valid) begin
        tests_run++; if (out_data !== exp_q[0]) begin
          tests_failed++; $display("FAIL unmask_data: got %h expected %h", out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      step();
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL unmask_timeout: %0d entries missing, expected 0", exp_q.size()); end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bit prev_en;
    int cap_pops;
    out_ready = 1'b0;
    load(2, 3);
    build_expected('1);
    for (int c = 0; c < 30 && out_level != 3'd3; c++) step();
    tests_run++; if (out_level !== 3'd3) begin tests_failed++; $display("FAIL wrap_fill: got %0d expected 3", out_level); end
    load(2, 6);
    build_expected('1);
    prev_en  = 1'b0;
    cap_pops = 0;
    // Pop only in the capture cycle so push and pop land on the same edge.
    for (int c = 0; c < 200 && cap_pops < 6; c++) begin
      out_ready = prev_en;
      if (out_valid && out_ready) begin
        tests_run++; if (out_data !== exp_q[0]) begin
          tests_failed++; $display("FAIL wrap_data: got %h expected %h", out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      prev_en = (q_rd_en != '0);
      step();
      if (out_ready) begin
        cap_pops++;
        tests_run++; if (out_level !== 3'd3) begin
          tests_failed++; $display("FAIL wrap_level_%0d: got %0d expected 3", cap_pops, out_level);
        end
      end
    end
    tests_run++; if (cap_pops != 6) begin tests_failed++; $display("FAIL wrap_pops: got %0d expected 6", cap_pops); end
    out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
      if (out_valid) begin
        tests_run++; if (out_data !== exp_q[0]) begin
          tests_failed++; $display("FAIL wrap_tail: got %h expected %h", out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      step();
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL wrap_timeout: %0d entries missing, expected 0", exp_q.size()); end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [CH-1:0] m;
    for (int r = 0; r < 6; r++) begin
      ch_mask = '0;
      repeat (2) step();
      m = CH'($urandom_range(1, 15));
      for (int k = 0; k < CH; k++) load(k, $urandom_range(0, 4));
      build_expected(m);
      ch_mask = m;
      for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
        out_ready = ($urandom_range(0, 1) == 1);
        if (out_valid && out_ready) begin
          tests_run++; if (out_data !== exp_q[0]) begin
            tests_failed++; $display("FAIL rand_data_r%0d: got %h expected %h", r, out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        step();
      end
      out_ready = 1'b0;
      tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rand_timeout_r%0d: %0d missing, expected 0", r, exp_q.size()); end
      repeat (6) step();
      tests_run++; if (out_level !== '0) begin tests_failed++; $display("FAIL rand_leftover_r%0d: level %0d expected 0", r, out_level); end
      ch_mask = '0;
      repeat (2) step();
      for (int k = 0; k < CH; k++) begin src_q[k].delete(); mdl_q[k].delete(); end
      refresh_stat();
    end
    ch_mask = '1;
    tests_run++; if (drop_cnt !== '0) begin tests_failed++; $display("FAIL rand_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_reset_mid_rd();
    int hits;
    hits = 0;
    ch_mask = '1;
    out_ready = 1'b0;
    load(3, 2);
    for (int c = 0; c < 40 && hits < 2; c++) begin
      step();
      if (q_rd_en != '0) hits++;
    end
    tests_run++; if (hits != 2) begin tests_failed++; $display("FAIL rstrd_reach: got %0d reads expected 2", hits); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (q_rd_en !== '0)   begin tests_failed++; $display("FAIL rstrd_rd_en: got %b expected 0", q_rd_en); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstrd_valid: got %b expected 0", out_valid); end
    tests_run++; if (out_level !== '0) begin tests_failed++; $display("FAIL rstrd_level: got %0d expected 0", out_level); end
    tests_run++; if (ch_pend !== '0)   begin tests_failed++; $display("FAIL rstrd_pend: got %b expected 0", ch_pend); end
    for (int k = 0; k < CH; k++) begin src_q[k].delete(); mdl_q[k].delete(); end
    exp_q.delete();
    load(1, 1);
    load(0, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++; if (q_rd_en !== '0 || ch_pend !== '0 || out_valid !== 1'b0 || drop_cnt !== '0) begin
        tests_failed++; $display("FAIL rstrd_hold_c%0d: rd_en %b pend %b valid %b drop %0d expected all 0",
                                 c, q_rd_en, ch_pend, out_valid, drop_cnt);
      end
    end
    model_last = CH - 1;
    build_expected('1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
      if (out_valid) begin
        tests_run++; if (out_data !== exp_q[0]) begin
          tests_failed++; $display("FAIL rstrd_order: got %h expected %h", out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      step();
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rstrd_timeout: %0d entries missing, expected 0", exp_q.size()); end
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    ch_mask   = '1;
    out_ready = 1'b0;
    q_rd_stat = '0;
    q_rd_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_wrap();
    test_random();
    test_reset_mid_rd();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
